// File: rtl/util_fifo_unpack_if.sv
// util_fifo_unpack_if: groups the FIFO read port and the narrow beat stream
// of util_fifo_unpack.
//   FifoEmptyN  FIFO has a word; FifoRData is valid
//   FifoRData   FIFO head word (OW*RATIO bits), combinational
//   FifoRead    pop request; the FIFO pops when FifoRead & FifoEmptyN
//   OutValid    beat valid
//   OutReady    downstream accepts the beat
//   OutData     current slice (OW bits)
//   OutLast     current beat is the final slice of its word
// Modports: master = the unpacker, slave = the FIFO/downstream side.
interface util_fifo_unpack_if #(
  parameter int unsigned OW    = 8,
  parameter int unsigned RATIO = 4
);
  logic                FifoEmptyN;
  logic [OW*RATIO-1:0] FifoRData;
  logic                FifoRead;
  logic                OutValid;
  logic                OutReady;
  logic [OW-1:0]       OutData;
  logic                OutLast;

  modport master (
    input  FifoEmptyN, FifoRData, OutReady,
    output FifoRead, OutValid, OutData, OutLast
  );

  modport slave (
    output FifoEmptyN, FifoRData, OutReady,
    input  FifoRead, OutValid, OutData, OutLast
  );
endinterface

// File: rtl/util_fifo_unpack.sv
// util_fifo_unpack: pops full-width words from a FIFO read port and emits each
// as RATIO narrow beats on a valid/ready stream with a last-beat flag.
// Ports:
//   Clk    FIFO read clock
//   Rst    synchronous, active-high reset
//   Flush  drop the held word and slice position (FIFO untouched)
//   Busy   a word is held
//   bus    util_fifo_unpack_if master: FIFO read port + beat stream
// Parameters: OW beat width, RATIO beats per word, LSB_FIRST slice order.
module util_fifo_unpack #(
  parameter int unsigned OW        = 8,
  parameter int unsigned RATIO     = 4,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Flush,
  output logic               Busy,
  util_fifo_unpack_if.master bus
);

  localparam int unsigned DW   = OW * RATIO;
  localparam int unsigned CntW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(RATIO - 1);

  typedef enum logic {StEmpty, StHold} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   hold_q, hold_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            hold_valid;
  logic            at_last;
  logic            take;
  logic            word_done;
  logic            pop;
  logic [CntW-1:0] slice_sel;
  logic [RATIO-1:0][OW-1:0] slices;

  assign hold_valid = (state_q == StHold);
  assign at_last    = (cnt_q == CntMax);
  assign take       = hold_valid & bus.OutReady;
  assign word_done  = take & at_last;
  // Refill in the same cycle the last beat leaves, so words run back-to-back.
  assign pop        = !Rst & !Flush & bus.FifoEmptyN & (!hold_valid | word_done);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    if (Flush) begin
      state_d = StEmpty;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (pop) begin
            state_d = StHold;
            hold_d  = bus.FifoRData;
            cnt_d   = '0;
          end
        end
        StHold: begin
          if (pop) begin
            hold_d = bus.FifoRData;
            cnt_d  = '0;
          end else if (word_done) begin
            state_d = StEmpty;
            cnt_d   = '0;
          end else if (take) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= StEmpty;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  // MSB-first walks the slices downward from the top of the word.
  always_comb begin
    slice_sel = cnt_q;
    if (!LSB_FIRST) begin
      slice_sel = CntMax - cnt_q;
    end
  end

  assign slices       = hold_q;
  assign bus.OutData  = slices[slice_sel];
  assign bus.OutValid = hold_valid;
  assign bus.OutLast  = hold_valid & at_last;
  assign bus.FifoRead = pop;
  assign Busy         = hold_valid;

endmodule
